// File: rtl/serial_feed_pkg.sv
// rtl/serial_feed_pkg.sv - shared types and frame-length helper for serial_word_feeder
// Optional feature macro: PARITY_BIT_EN (appends an even-parity bit to every frame)
package serial_feed_pkg;

   localparam int FEED_STATE_W = 1;

   typedef enum logic [FEED_STATE_W-1:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } feed_state_t;

   function automatic int frame_len(input int width);
`ifdef PARITY_BIT_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// rtl/ser_bit_counter.sv - bit-position counter for one serial frame
// Counts 0..N-1 and holds at N-1; tc flags the final bit of the frame.
module ser_bit_counter #(
   parameter int N  = 8,
   parameter int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          enable,
   output logic [CW-1:0] count,
   output logic          tc
);

   assign tc = (count == CW'(N - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (enable && !tc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/serial_word_feeder.sv
// rtl/serial_word_feeder.sv - parallel word to qualified serial bit stream feeder
// Optional feature macro: PARITY_BIT_EN (frame carries an extra even-parity bit)
module serial_word_feeder
   import serial_feed_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy
);

   localparam int N  = frame_len(WIDTH);
   localparam int CW = $clog2(N + 1);

   feed_state_t      state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    count;
   logic             tc;
   logic             accept;
   logic             next_is_last;
   logic             first_bit;
   logic             head;
   logic             next_bit;
   logic [WIDTH-1:0] load_sreg;
   logic [WIDTH-1:0] shift_sreg;

   assign din_ready    = rst && ((state == IDLE) || ((state == SHIFT) && tc));
   assign accept       = din_valid && din_ready;
   assign next_is_last = (count == CW'(N - 2));

   // sreg always holds the bits still to be shown, oldest at the output end
   assign first_bit  = MSB_FIRST ? din[WIDTH-1] : din[0];
   assign load_sreg  = MSB_FIRST ? {din[WIDTH-2:0], 1'b0} : {1'b0, din[WIDTH-1:1]};
   assign head       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
   assign shift_sreg = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

`ifdef PARITY_BIT_EN
   logic parity;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         parity <= 1'b0;
      end else if (accept) begin
         parity <= ^din;
      end
   end

   assign next_bit = next_is_last ? parity : head;
`else
   assign next_bit = head;
`endif

   ser_bit_counter #(
      .N  (N),
      .CW (CW)
   ) u_bit_counter (
      .clk    (clk),
      .rst    (rst),
      .load   (accept || ((state == SHIFT) && tc)),
      .enable ((state == SHIFT) && !tc),
      .count  (count),
      .tc     (tc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         sreg        <= '0;
         ser_out     <= 1'b0;
         ser_valid   <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         busy        <= 1'b0;
      end else if (accept) begin
         state       <= SHIFT;
         sreg        <= load_sreg;
         ser_out     <= first_bit;
         ser_valid   <= 1'b1;
         frame_start <= 1'b1;
         frame_end   <= 1'b0;
         busy        <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               state <= IDLE;
            end
            SHIFT: begin
               if (tc) begin
                  state       <= IDLE;
                  sreg        <= '0;
                  ser_out     <= 1'b0;
                  ser_valid   <= 1'b0;
                  frame_start <= 1'b0;
                  frame_end   <= 1'b0;
                  busy        <= 1'b0;
               end else begin
                  sreg        <= shift_sreg;
                  ser_out     <= next_bit;
                  frame_start <= 1'b0;
                  frame_end   <= next_is_last;
                  busy        <= !next_is_last;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_word_feeder.sv
// tb/tb_serial_word_feeder.sv - self-checking bench for serial_word_feeder
// Instance 0 is MSB-first, instance 1 LSB-first; PARITY_BIT_EN selects the parity scenario.
module tb_serial_word_feeder;

`ifdef PARITY_BIT_EN
   localparam int NF = 9;
`else
   localparam int NF = 8;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] din [2];
   logic       dv  [2];
   logic       rdy [2];
   logic       so  [2];
   logic       sv  [2];
   logic       fs  [2];
   logic       fe  [2];
   logic       bz  [2];

   int checks;
   int errors;

   bit       m_act  [2];
   logic [7:0] m_word [2];
   int       m_pos  [2];
   bit       m_msb  [2];

   serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .din(din[0]), .din_valid(dv[0]), .din_ready(rdy[0]),
      .ser_out(so[0]), .ser_valid(sv[0]), .frame_start(fs[0]), .frame_end(fe[0]), .busy(bz[0])
   );

   serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .din(din[1]), .din_valid(dv[1]), .din_ready(rdy[1]),
      .ser_out(so[1]), .ser_valid(sv[1]), .frame_start(fs[1]), .frame_end(fe[1]), .busy(bz[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame bit p of word w: data bits in the chosen order, then parity.
   function automatic logic exp_bit(input logic [7:0] w, input bit msb, input int p);
      if (p >= 8) return ^w;
      return msb ? w[7 - p] : w[p];
   endfunction

   function automatic logic m_ready(input int i);
      return rst && (!m_act[i] || m_pos[i] == NF - 1);
   endfunction

   // Reference model: which word is on the line and which bit of it is showing.
   initial begin
      m_msb[0] = 1'b1;
      m_msb[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 1'b0; m_pos[i] = 0; m_word[i] = '0;
      end
      forever begin
         @(posedge clk or negedge rst);
         for (int i = 0; i < 2; i++) begin
            if (!rst) begin
               m_act[i] = 1'b0;
               m_pos[i] = 0;
            end else if (dv[i] && m_ready(i)) begin
               m_act[i]  = 1'b1;
               m_word[i] = din[i];
               m_pos[i]  = 0;
            end else if (m_act[i]) begin
               if (m_pos[i] == NF - 1) m_act[i] = 1'b0;
               else m_pos[i]++;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("i%0d ser_valid", i), sv[i], m_act[i]);
            chk($sformatf("i%0d ser_out", i), so[i],
                m_act[i] ? exp_bit(m_word[i], m_msb[i], m_pos[i]) : 1'b0);
            chk($sformatf("i%0d frame_start", i), fs[i], m_act[i] && m_pos[i] == 0);
            chk($sformatf("i%0d frame_end", i), fe[i], m_act[i] && m_pos[i] == NF - 1);
            chk($sformatf("i%0d busy", i), bz[i], m_act[i] && m_pos[i] != NF - 1);
            chk($sformatf("i%0d din_ready", i), rdy[i], m_ready(i));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   initial begin
      bit b4_bits [8] = '{1, 0, 1, 1, 0, 1, 0, 0};
      bit b5a_lsb [8] = '{0, 1, 0, 1, 1, 0, 1, 0};
      bit baa     [3] = '{1, 0, 1};
      checks = 0;
      errors = 0;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         din[i] = '0; dv[i] = 1'b0;
      end
      mid();
      chk("reset ser_valid", sv[0], 1'b0);
      chk("reset din_ready", rdy[0], 1'b0);
      chk("reset frame_start", fs[1], 1'b0);
      idle(2);
      rst = 1'b1;
      mid();
      chk("post-reset din_ready", rdy[0], 1'b1);
      idle(2);

`ifdef PARITY_BIT_EN
      din[0] = 8'h07; dv[0] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         cyc();
         if (k == 1) dv[0] = 1'b0;
         mid();
         if (k == 9) begin
            chk("par07 bit9", so[0], 1'b1);
            chk("par07 frame_end", fe[0], 1'b1);
         end
         if (k == 10) chk("par07 end valid", sv[0], 1'b0);
      end
      din[0] = 8'h03; dv[0] = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         cyc();
         if (k == 1) dv[0] = 1'b0;
         mid();
         if (k == 9) begin
            chk("par03 bit9", so[0], 1'b0);
            chk("par03 frame_end", fe[0], 1'b1);
            chk("par03 din_ready", rdy[0], 1'b1);
         end
      end
      idle(3);
`else
      // MSB-first single frame of 8'hB4
      din[0] = 8'hB4; dv[0] = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         cyc();
         if (k == 1) dv[0] = 1'b0;
         mid();
         if (k <= 8) chk($sformatf("b4 bit%0d", k), so[0], b4_bits[k-1]);
         chk($sformatf("b4 start c%0d", k), fs[0], k == 1);
         chk($sformatf("b4 end c%0d", k), fe[0], k == 8);
         if (k == 9) chk("b4 valid after", sv[0], 1'b0);
      end
      idle(2);

      // LSB-first 8'h01 and din_ready timing
      din[1] = 8'h01; dv[1] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         if (k == 1) dv[1] = 1'b0;
         mid();
         chk($sformatf("h01 bit%0d", k), so[1], k == 1);
         chk($sformatf("h01 ready c%0d", k), rdy[1], k == 8);
      end
      idle(3);

      // Back-to-back 8'hFF then 8'h00 with din_valid held high
      din[0] = 8'hFF; dv[0] = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         cyc();
         if (k == 8) din[0] = 8'h00;
         if (k == 9) dv[0] = 1'b0;
         mid();
         chk($sformatf("b2b valid c%0d", k), sv[0], k <= 16);
         chk($sformatf("b2b bit c%0d", k), so[0], k <= 8);
         chk($sformatf("b2b start c%0d", k), fs[0], k == 1 || k == 9);
         chk($sformatf("b2b end c%0d", k), fe[0], k == 8 || k == 16);
      end
      idle(2);

      // Reset during bit 4 of 8'hAA
      din[0] = 8'hAA; dv[0] = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         cyc();
         if (k == 1) dv[0] = 1'b0;
         mid();
         chk($sformatf("aa bit%0d", k), so[0], baa[k-1]);
      end
      cyc();
      #1 rst = 1'b0;
      mid();
      chk("aa reset valid", sv[0], 1'b0);
      chk("aa reset out", so[0], 1'b0);
      cyc();
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         mid();
         chk($sformatf("aa release valid %0d", k), sv[0], 1'b0);
         chk($sformatf("aa release ready %0d", k), rdy[0], 1'b1);
         cyc();
      end

      // din changing while busy must not alter the frame
      din[1] = 8'h5A; dv[1] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         din[1] = 8'($urandom);
         if (k >= 7) dv[1] = 1'b0;
         mid();
         chk($sformatf("5a bit%0d", k), so[1], b5a_lsb[k-1]);
      end
      idle(3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
